// File: rtl/mod_sched_pkg.sv
// Shared types and constants for the round-robin modulo scheduler.
// No logic; state encodings and default sizing only.
// Not applicable: no datapath, no flow control.
package mod_sched_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_IDW   = 2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'b00;
  localparam state_t LOAD = 2'b01;
  localparam state_t SUB  = 2'b10;
  localparam state_t DONE = 2'b11;

endpackage

// File: rtl/mod_sched_if.sv
// Client-side bundle for the shared modulo scheduler: requests, operands, results.
// Pure wiring; no latency of its own.
// Flow control is level req with a one-cycle gnt; results are a one-cycle done pulse.
interface mod_sched_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] dividend;
  logic [NREQ*WIDTH-1:0] divisor;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [WIDTH-1:0]      remainder;
  logic [WIDTH-1:0]      quotient;
  logic                  dz_err;

  // client blocks drive requests and operands
  modport master (
    output req, dividend, divisor,
    input  gnt, busy, done, done_id, remainder, quotient, dz_err
  );

  // the scheduler consumes requests and returns results
  modport slave (
    input  req, dividend, divisor,
    output gnt, busy, done, done_id, remainder, quotient, dz_err
  );
endinterface

// File: rtl/mod_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with wrap.
// Zero latency (pure combinational).
// No backpressure; the caller decides when the pick is used.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic            vld
);

  int j;

  // walk NREQ slots starting at ptr; the first pending one wins
  always_comb begin
    gnt_oh = '0;
    vld    = 1'b0;
    j      = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!vld && req[j]) begin
        gnt_oh[j] = 1'b1;
        vld       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_sched.sv
// Round-robin scheduler in front of one iterative subtract-based modulo unit.
// gnt at cycle t -> done at t+q+2 (q = quotient), or t+1 when the divisor is 0.
// Non-preemptive: requests are only arbitrated in IDLE; others wait holding req.
module mod_sched
  import mod_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = DEF_IDW
) (
  input  logic     clk,
  input  logic     reset,
  mod_sched_if.slave bus
);

  state_t            state, nxt;
  logic [IDW-1:0]    id, ptr, win_id;
  logic [NREQ-1:0]   arb_oh;
  logic              arb_vld;
  logic [WIDTH-1:0]  temp, div, count;
  logic [WIDTH-1:0]  cur_dvd, cur_dvs;
  logic [WIDTH-1:0]  rem_q, quo_q;
  logic [IDW-1:0]    id_q;
  logic              dz_q;
  logic              ltd;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req    (bus.req),
    .ptr    (ptr),
    .gnt_oh (arb_oh),
    .vld    (arb_vld)
  );

  // one-hot grant to binary requester index
  always_comb begin
    win_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_oh[i]) win_id = IDW'(i);
    end
  end

  assign cur_dvd = bus.dividend[id*WIDTH +: WIDTH];
  assign cur_dvs = bus.divisor[id*WIDTH +: WIDTH];
  assign ltd     = (temp < div);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (arb_vld) nxt = LOAD;
      LOAD:    nxt = (cur_dvs == '0) ? DONE : SUB;
      SUB:     if (ltd) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state-decoded outputs: grant in LOAD, pulse in DONE
  always_comb begin
    bus.gnt  = '0;
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
    if (state == LOAD) bus.gnt[id] = 1'b1;
  end

  // winner capture, operand load, iterative subtract and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id    <= '0;
      ptr   <= '0;
      temp  <= '0;
      div   <= '0;
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      id_q  <= '0;
      dz_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_vld) id <= win_id;
        end
        LOAD: begin
          temp  <= cur_dvd;
          div   <= cur_dvs;
          count <= '0;
          ptr   <= (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
          // divide-by-zero skips SUB; results are ready for DONE next cycle
          if (cur_dvs == '0) begin
            rem_q <= cur_dvd;
            quo_q <= '0;
            dz_q  <= 1'b1;
            id_q  <= id;
          end
        end
        SUB: begin
          if (ltd) begin
            rem_q <= temp;
            quo_q <= count;
            dz_q  <= 1'b0;
            id_q  <= id;
          end else begin
            // compare gates the subtract, so it never wraps
            temp  <= temp - div;
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.remainder = rem_q;
  assign bus.quotient  = quo_q;
  assign bus.done_id   = id_q;
  assign bus.dz_err    = dz_q;

endmodule

// File: tb/tb_mod_sched.sv
// Directed bench for mod_sched with an expected-result queue.
module tb_mod_sched;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int IW = 2;

  typedef struct {
    int          id;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        dz;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  mod_sched_if #(.WIDTH(W), .NREQ(NR), .IDW(IW)) bus ();

  mod_sched #(.WIDTH(W), .NREQ(NR), .IDW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.id  = id;
    e.dz  = (b == 0);
    e.rem = (b == 0) ? a : a % b;
    e.quo = (b == 0) ? 32'd0 : a / b;
    e.lat = (b == 0) ? 1 : int'(e.quo) + 2;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(output int t);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.gnt != '0) break;
    end
    chk("gnt_seen", 32'(bus.gnt != '0), 32'd1);
    t = cyc;
  endtask

  task automatic wait_done_check(input string tag, input int t0);
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) break;
      tick();
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
      chk({tag, "_id"},  32'(bus.done_id), 32'(e.id));
      chk({tag, "_rem"}, bus.remainder, e.rem);
      chk({tag, "_quo"}, bus.quotient, e.quo);
      chk({tag, "_dz"},  32'(bus.dz_err), 32'(e.dz));
    end
    tick();
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
  endtask

  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    bus.dividend[id*W +: W] = a;
    bus.divisor[id*W +: W]  = b;
  endtask

  task automatic job(input string tag, input int id, input logic [31:0] a,
                     input logic [31:0] b, input bit change_after);
    int t;
    set_ops(id, a, b);
    push_exp(id, a, b);
    bus.req[id] = 1'b1;
    wait_gnt(t);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << id));
    bus.req[id] = 1'b0;
    if (change_after) begin
      // operands were captured at this edge; scribble over them afterwards
      tick();
      set_ops(id, a + 32'd99, b + 32'd1);
    end
    wait_done_check(tag, t);
  endtask

  initial begin
    int t, tp;
    reset        = 1'b0;
    bus.req      = '0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_gnt",  32'(bus.gnt),  32'd0);
    chk("rst_rem",  bus.remainder, 32'd0);
    chk("rst_quo",  bus.quotient,  32'd0);
    chk("rst_dz",   32'(bus.dz_err), 32'd0);
    reset = 1'b1;
    tick();

    job("single",  0, 32'd17, 32'd5, 1'b0);
    job("divzero", 2, 32'd9,  32'd0, 1'b0);
    job("lt",      1, 32'd3,  32'd7, 1'b0);
    job("max",     0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    job("hold",    0, 32'd20, 32'd6, 1'b1);
    job("eq",      3, 32'd7,  32'd7, 1'b0);

    // all four contend with pointer at 0; dividends 0, divisors 1
    for (int i = 0; i < NR; i++) set_ops(i, 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) push_exp(k % NR, 32'd0, 32'd1);
    bus.req = 4'b1111;
    tp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(t);
      if (k == 4) bus.req = '0;
      chk("rr_gnt", 32'(bus.gnt), 32'(1 << (k % NR)));
      if (k > 0) chk("rr_spacing", 32'(t - tp), 32'd4);
      tp = t;
      wait_done_check("rr", t);
    end

    // reset in the middle of a long SUB run
    set_ops(0, 32'd1000, 32'd3);
    bus.req[0] = 1'b1;
    wait_gnt(t);
    bus.req[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_done", 32'(bus.done), 32'd0);
    chk("mid_gnt",  32'(bus.gnt),  32'd0);
    chk("mid_rem",  bus.remainder, 32'd0);
    set_ops(1, 32'd11, 32'd4);
    set_ops(3, 32'd5,  32'd2);
    bus.req = 4'b1010;
    tick();
    tick();
    reset = 1'b1;
    push_exp(1, 32'd11, 32'd4);
    push_exp(3, 32'd5,  32'd2);
    wait_gnt(t);
    chk("post_gnt1", 32'(bus.gnt), 32'b0010);
    bus.req[1] = 1'b0;
    wait_done_check("post1", t);
    wait_gnt(t);
    chk("post_gnt3", 32'(bus.gnt), 32'b1000);
    bus.req[3] = 1'b0;
    wait_done_check("post3", t);

    for (int i = 0; i < 4; i++) tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("sb_empty",  32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_sched.md
Name: mod_sched

Overview:
- Round-robin scheduler that shares one iterative subtract-based modulo datapath among NREQ requesters.
- Arbitrates pending requests and captures the winner's operands.
- Sequences LOAD/SUB/DONE, then returns remainder, quotient and requester ID with a one-cycle done pulse.
- Sits between client blocks and the shared modulo resource; instantiates the datapath registers internally.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width (must equal clog2(NREQ)).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- req  in  NREQ  per-requester request, level.
- dividend  in  NREQ*WIDTH  packed; slice i belongs to requester i.
- divisor  in  NREQ*WIDTH  packed; slice i belongs to requester i.
- gnt  out  NREQ  one-hot; high for exactly one cycle when requester's operands are captured.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result fields valid.
- done_id  out  IDW  requester that owns the result.
- remainder  out  WIDTH  dividend mod divisor.
- quotient  out  WIDTH  floor(dividend/divisor).
- dz_err  out  1  high with done when divisor was 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer 0 (requester 0 has highest priority first); internal regs 0.
- States: IDLE, LOAD, SUB, DONE (2-bit encoding from package).
- IDLE:
  - If any req bit is set, the arbiter picks the first set bit searching from ptr upward with wrap.
  - Winner ID is registered; next state is LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle):
  - gnt[id]=1.
  - temp<=dividend[id], div<=divisor[id], quotient count<=0.
  - ptr<=id+1 mod NREQ.
  - Next state: DONE if divisor[id]==0, else SUB.
- SUB:
  - If temp<div (unsigned), go to DONE.
  - Else temp<=temp-div, count<=count+1, stay in SUB.
- DONE (1 cycle):
  - done=1, done_id=id, remainder=temp, quotient=count.
  - dz_err=1 only for divisor 0, in which case remainder=dividend and quotient=0.
  - Next state: IDLE.
- Result outputs are registered and held until the next DONE. done and gnt are 0 outside their states.
- Latency: with gnt at cycle t, done occurs at t+q+2 (q = quotient), or t+1 for divisor 0.
- A requester must hold its operands valid through its gnt cycle and may change them afterward.
- A req still high after gnt is treated as a new request and re-arbitrated with the updated pointer.
- req changes during LOAD/SUB/DONE are ignored until IDLE; there is no preemption.
- Simultaneous requests are served strictly round-robin; starvation-free, with worst-case wait NREQ-1 jobs.
- Min back-to-back spacing: DONE to next gnt is 2 cycles (via IDLE).
- dividend<divisor: SUB lasts 1 cycle, remainder=dividend, quotient=0.
- dividend==divisor: quotient=1, remainder=0.
- Unsigned arithmetic only. Subtraction cannot underflow because it is gated by the compare.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. The job is dropped with no done, and the pointer returns to 0.

Decomposition:
- Package mod_sched_pkg holds:
  - state localparams IDLE=2'b00, LOAD=2'b01, SUB=2'b10, DONE=2'b11;
  - default WIDTH/NREQ constants.
- One sub-module, rr_arbiter: combinational first-set search from ptr with wrap; outputs a one-hot grant vector and a valid flag.
- The FSM, datapath registers and pointer update stay in mod_sched.

Test Plan:
- Single job: req[0] with 17 mod 5 -> gnt[0] one cycle, done 5 cycles later, remainder=2, quotient=3, done_id=0, dz_err=0.
- Divide by zero: req[2] with 9 mod 0 -> gnt[2], done next cycle, dz_err=1, remainder=9, quotient=0.
- Round-robin fairness: req=4'b1111 held, all divisors 1, dividends 0 -> grant order 0,1,2,3,0; each gnt spaced 4 cycles; no repeats before wrap.
- Boundaries:
  - 3 mod 7 -> remainder=3, quotient=0, SUB 1 cycle.
  - 7 mod 7 -> remainder=0, quotient=1.
  - 0xFFFFFFFF mod 0xFFFFFFFF -> remainder 0.
- Reset mid-SUB: start 1000 mod 3, drive reset=0 after 10 cycles -> busy/done/gnt are 0 immediately. After release, req[1] is granted before req[3] (ptr=0), and no stale done appears.
- Operand hold: change dividend[0] the cycle after gnt[0] -> result reflects the captured value.
